cmd_exec: RTL and testbench
===========================

# cmd_exec

Command executor downstream of the USB bridge. It synchronises the bridge's command strobe into the system clock domain, decodes the 16-bit command and its 32-bit parameter, and updates the acquisition configuration registers or runs a start/stop handshake with the acquisition core. When the command is done it returns a stretched finish pulse and a 16-bit result code, which the bridge sends back to the host.

## Interface
- `FINISH_HOLD`, default 8: cycles `o_cmd_finish` stays high, then the minimum low cycles before the next finish. Must be ≥ 4.
- `ACQ_TIMEOUT`, default 24'd10_000_000: maximum cycles to wait for `i_acq_done` after START.
- `i_clk_sys`, in, 1: system clock. This is the block's only clock.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_cmd_come`, in, 1: command-valid level from the USB clock domain. It is asynchronous to `i_clk_sys`.
- `i_cmd`, in, 16: command code. Stable while `i_cmd_come` is high.
- `i_cmd_param`, in, 32: command parameter. Stable while `i_cmd_come` is high.
- `o_cmd_finish`, out, 1: stretched finish pulse to the bridge.
- `o_cmd_finish_code`, out, 16: result code. Valid from the rising edge of `o_cmd_finish` and held until the next finish.
- `o_gain`, out, 8: receiver gain.
- `o_prf_period`, out, 24: pulse repetition period in clocks.
- `o_sample_cnt`, out, 16: samples per shot.
- `o_acq_start`, out, 1: one-cycle start pulse to the acquisition core.
- `o_acq_stop`, out, 1: one-cycle stop pulse to the acquisition core.
- `i_acq_done`, in, 1: acquisition-core done level, synchronous to `i_clk_sys`.
- `o_busy`, out, 1: high whenever the state is not IDLE.

## Operation
- **Command detection.** `i_cmd_come` passes through a 2-FF synchroniser plus a history flop. A new command is the rising edge: synchronised value 1, history value 0.
- **Capture.** In IDLE, the edge cycle latches `i_cmd`/`i_cmd_param` into internal registers and moves to DECODE.
- **Edges outside IDLE.** An edge in any other state is ignored. This cannot happen with the bridge, which blocks reception until it has seen the finish.
- **Decode.** Codes, with result codes OK=16'h0000, RANGE=16'h0002, TIMEOUT=16'h0003, UNKNOWN=16'hFFFF:
  - 16'h0001 SET_GAIN: `o_gain` ← param[7:0]. RANGE if param[31:8] ≠ 0, and `o_gain` is left unchanged.
  - 16'h0002 SET_PRF: `o_prf_period` ← param[23:0]. RANGE, register unchanged, if param[31:24] ≠ 0 or param[23:0] < 24'd100.
  - 16'h0003 SET_SAMPLES: `o_sample_cnt` ← param[15:0]. RANGE, register unchanged, if the value is 0 or > 16'd8192.
  - 16'h0004 START: pulse `o_acq_start`, go to ACQ_WAIT.
  - 16'h0005 STOP: pulse `o_acq_stop`, result OK.
  - 16'h0006 DEFAULTS: reload the reset values of all config registers, result OK.
  - Any other code: UNKNOWN, no register changes.
- **States and transitions:**
  - IDLE → DECODE on an edge.
  - DECODE → ACQ_WAIT for START; otherwise → FIN_HI, with the result code latched.
  - ACQ_WAIT: a 24-bit counter counts up from 0.
    - `i_acq_done` = 1 → FIN_HI with OK.
    - Counter = ACQ_TIMEOUT−1 → pulse `o_acq_stop`, → FIN_HI with TIMEOUT.
    - If done and timeout occur in the same cycle, done wins: OK, no stop pulse.
  - FIN_HI: `o_cmd_finish` = 1 for FINISH_HOLD cycles → FIN_LO.
  - FIN_LO: `o_cmd_finish` = 0 for FINISH_HOLD cycles → IDLE.
- **Hold counter.** 8 bits wide; it saturates and is cleared on each state entry.
- **Reset (any time, including mid-command).** All outputs return to these values and the state goes to IDLE; no finish is emitted for an aborted command.
  - `o_gain` = 8'd32
  - `o_prf_period` = 24'd50_000
  - `o_sample_cnt` = 16'd1024
  - `o_cmd_finish_code` = 0
  - `o_cmd_finish`, `o_acq_start`, `o_acq_stop`, `o_busy` = 0

## Timing
- **Edge detection.** The edge is seen 2–3 `i_clk_sys` cycles after `i_cmd_come` rises. Capture happens on that cycle.
- **DECODE latency.** DECODE is the cycle after capture. Register writes and `o_acq_start`/`o_acq_stop` are registered outputs, visible one cycle after DECODE.
- **Finish on non-START commands.** `o_cmd_finish` rises on the cycle after DECODE, which is 2 cycles after capture.
- **Finish on START.** `o_cmd_finish` rises the cycle after `i_acq_done` is sampled high in ACQ_WAIT.
- **Result code.** `o_cmd_finish_code` is updated in the same cycle `o_cmd_finish` rises.
- **Finish pulse width.** `o_cmd_finish` high lasts exactly FINISH_HOLD cycles. The default of 8 covers any USB clock ≥ i_clk_sys/2 for the bridge's 2-FF edge detect.
- **Minimum spacing.** The minimum command-to-command turnaround is 2·FINISH_HOLD + 4 cycles.

## Structure
- **Shared package `usb_cmd_pkg`:**
  - command code constants CMD_SET_GAIN … CMD_DEFAULTS;
  - result codes RC_OK, RC_RANGE, RC_TIMEOUT, RC_UNKNOWN;
  - the config reset values;
  - the state encoding as one-hot localparams.
- **Sub-module `sync_edge`:** the 2-FF synchroniser, history flop and rising-edge output, reused for other asynchronous strobes.

## Test plan
- **SET_GAIN, valid.** Raise `i_cmd_come` with cmd 16'h0001 and param 32'h0000_0050 → `o_gain` = 8'h50; one finish pulse 8 cycles wide; code 16'h0000.
- **SET_SAMPLES, out of range.** param 32'd9000 → `o_sample_cnt` stays 1024; code 16'h0002.
- **Unknown command.** cmd 16'h00AA → code 16'hFFFF; no config change; `o_busy` drops 16 cycles after the finish rises.
- **START with done.** `i_acq_done` is asserted 50 cycles after `o_acq_start` → exactly one `o_acq_start` pulse; finish the next cycle; code 0; no stop pulse.
- **START with timeout.** Set ACQ_TIMEOUT=100 and never assert done → `o_acq_stop` pulses at count 99; code 16'h0003.
- **Reset mid-operation, then re-issue.**
  - Assert `i_rst_n`=0 during ACQ_WAIT → all outputs at reset values; no finish pulse.
  - After release, a new SET_PRF with 24'd200 → `o_prf_period` = 200; code OK.

Source files
------------

// File: rtl/usb_cmd_pkg.sv
// Shared constants for the USB command path: command codes, result codes,
// configuration reset values and the executor state encoding.
package usb_cmd_pkg;

  localparam logic [15:0] CMD_SET_GAIN    = 16'h0001;
  localparam logic [15:0] CMD_SET_PRF     = 16'h0002;
  localparam logic [15:0] CMD_SET_SAMPLES = 16'h0003;
  localparam logic [15:0] CMD_START       = 16'h0004;
  localparam logic [15:0] CMD_STOP        = 16'h0005;
  localparam logic [15:0] CMD_DEFAULTS    = 16'h0006;

  localparam logic [15:0] RC_OK      = 16'h0000;
  localparam logic [15:0] RC_RANGE   = 16'h0002;
  localparam logic [15:0] RC_TIMEOUT = 16'h0003;
  localparam logic [15:0] RC_UNKNOWN = 16'hFFFF;

  localparam logic [7:0]  GAIN_RST    = 8'd32;
  localparam logic [23:0] PRF_RST     = 24'd50_000;
  localparam logic [15:0] SAMPLES_RST = 16'd1024;

  localparam logic [23:0] PRF_MIN     = 24'd100;
  localparam logic [15:0] SAMPLES_MAX = 16'd8192;

  // One-hot state encoding
  localparam logic [4:0] ST_IDLE     = 5'b00001;
  localparam logic [4:0] ST_DECODE   = 5'b00010;
  localparam logic [4:0] ST_ACQ_WAIT = 5'b00100;
  localparam logic [4:0] ST_FIN_HI   = 5'b01000;
  localparam logic [4:0] ST_FIN_LO   = 5'b10000;

  typedef enum logic [4:0] {
    S_IDLE     = ST_IDLE,
    S_DECODE   = ST_DECODE,
    S_ACQ_WAIT = ST_ACQ_WAIT,
    S_FIN_HI   = ST_FIN_HI,
    S_FIN_LO   = ST_FIN_LO
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a history
// flop so a single-cycle rising-edge strobe can be produced.
module sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  // Synchroniser chain plus history flop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= i_async;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign o_rise = sync_q & ~hist_q;

endmodule

// File: rtl/cmd_exec.sv
// Command executor: decodes host commands from the USB bridge, updates the
// acquisition configuration, runs the start/stop handshake and returns a
// stretched finish pulse with a result code.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a synchronised rising edge of i_cmd_come
// DECODE   | command captured; apply config write or launch acquisition
// ACQ_WAIT | START issued; wait for i_acq_done or the timeout count
// FIN_HI   | o_cmd_finish held high for FINISH_HOLD cycles
// FIN_LO   | o_cmd_finish held low for FINISH_HOLD cycles before IDLE
import usb_cmd_pkg::*;

module cmd_exec #(
  // Must be at least 4 so the bridge's edge detector always sees the pulse.
  parameter int unsigned FINISH_HOLD = 8,
  parameter logic [23:0] ACQ_TIMEOUT = 24'd10_000_000
) (
  input  logic        i_clk_sys,
  input  logic        i_rst_n,
  input  logic        i_cmd_come,
  input  logic [15:0] i_cmd,
  input  logic [31:0] i_cmd_param,
  output logic        o_cmd_finish,
  output logic [15:0] o_cmd_finish_code,
  output logic [7:0]  o_gain,
  output logic [23:0] o_prf_period,
  output logic [15:0] o_sample_cnt,
  output logic        o_acq_start,
  output logic        o_acq_stop,
  input  logic        i_acq_done,
  output logic        o_busy
);

  localparam logic [7:0]  HOLD_LAST = 8'(FINISH_HOLD - 1);
  localparam logic [23:0] ACQ_LAST  = ACQ_TIMEOUT - 24'd1;

  state_t      state;
  logic        cmd_edge;
  logic [15:0] cmd_q;
  logic [31:0] param_q;
  logic [7:0]  hold_cnt;
  logic [7:0]  hold_inc;
  logic [23:0] acq_cnt;

  logic        gain_bad;
  logic        prf_bad;
  logic        samples_bad;
  logic [15:0] decode_rc;

  sync_edge u_cmd_sync (
    .i_clk   (i_clk_sys),
    .i_rst_n (i_rst_n),
    .i_async (i_cmd_come),
    .o_rise  (cmd_edge)
  );

  // Parameter range checks and result code for the captured command
  always_comb begin
    gain_bad    = (param_q[31:8] != 24'd0);
    prf_bad     = (param_q[31:24] != 8'd0) || (param_q[23:0] < PRF_MIN);
    samples_bad = (param_q[15:0] == 16'd0) || (param_q[15:0] > SAMPLES_MAX);
    decode_rc   = RC_UNKNOWN;
    case (cmd_q)
      CMD_SET_GAIN:    decode_rc = gain_bad    ? RC_RANGE : RC_OK;
      CMD_SET_PRF:     decode_rc = prf_bad     ? RC_RANGE : RC_OK;
      CMD_SET_SAMPLES: decode_rc = samples_bad ? RC_RANGE : RC_OK;
      CMD_START:       decode_rc = RC_OK;
      CMD_STOP:        decode_rc = RC_OK;
      CMD_DEFAULTS:    decode_rc = RC_OK;
      default:         decode_rc = RC_UNKNOWN;
    endcase
  end

  assign hold_inc = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;

  // Main sequencer: capture, decode, acquisition handshake, finish stretch
  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= S_IDLE;
      cmd_q             <= 16'd0;
      param_q           <= 32'd0;
      hold_cnt          <= 8'd0;
      acq_cnt           <= 24'd0;
      o_cmd_finish      <= 1'b0;
      o_cmd_finish_code <= RC_OK;
      o_gain            <= GAIN_RST;
      o_prf_period      <= PRF_RST;
      o_sample_cnt      <= SAMPLES_RST;
      o_acq_start       <= 1'b0;
      o_acq_stop        <= 1'b0;
    end else begin
      o_acq_start <= 1'b0;
      o_acq_stop  <= 1'b0;
      hold_cnt    <= hold_inc;
      case (state)
        S_IDLE: begin
          if (cmd_edge) begin
            cmd_q    <= i_cmd;
            param_q  <= i_cmd_param;
            hold_cnt <= 8'd0;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          hold_cnt <= 8'd0;
          if (cmd_q == CMD_START) begin
            o_acq_start <= 1'b1;
            acq_cnt     <= 24'd0;
            state       <= S_ACQ_WAIT;
          end else begin
            o_cmd_finish      <= 1'b1;
            o_cmd_finish_code <= decode_rc;
            state             <= S_FIN_HI;
            case (cmd_q)
              CMD_SET_GAIN:    if (!gain_bad)    o_gain       <= param_q[7:0];
              CMD_SET_PRF:     if (!prf_bad)     o_prf_period <= param_q[23:0];
              CMD_SET_SAMPLES: if (!samples_bad) o_sample_cnt <= param_q[15:0];
              CMD_STOP:        o_acq_stop <= 1'b1;
              CMD_DEFAULTS: begin
                o_gain       <= GAIN_RST;
                o_prf_period <= PRF_RST;
                o_sample_cnt <= SAMPLES_RST;
              end
              default: ;
            endcase
          end
        end
        S_ACQ_WAIT: begin
          // done takes priority over a coincident timeout
          if (i_acq_done) begin
            o_cmd_finish      <= 1'b1;
            o_cmd_finish_code <= RC_OK;
            hold_cnt          <= 8'd0;
            state             <= S_FIN_HI;
          end else if (acq_cnt == ACQ_LAST) begin
            o_acq_stop        <= 1'b1;
            o_cmd_finish      <= 1'b1;
            o_cmd_finish_code <= RC_TIMEOUT;
            hold_cnt          <= 8'd0;
            state             <= S_FIN_HI;
          end else begin
            acq_cnt <= acq_cnt + 24'd1;
          end
        end
        S_FIN_HI: begin
          if (hold_cnt == HOLD_LAST) begin
            o_cmd_finish <= 1'b0;
            hold_cnt     <= 8'd0;
            state        <= S_FIN_LO;
          end
        end
        S_FIN_LO: begin
          if (hold_cnt == HOLD_LAST) begin
            hold_cnt <= 8'd0;
            state    <= S_IDLE;
          end
        end
        default: begin
          o_cmd_finish <= 1'b0;
          hold_cnt     <= 8'd0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_cmd_exec.sv
// Directed bench for cmd_exec with an expected-result scoreboard.
module tb_cmd_exec;

  localparam int FH     = 8;
  localparam int ACQ_TO = 100;

  logic        i_clk_sys = 1'b0;
  logic        i_rst_n;
  logic        i_cmd_come;
  logic [15:0] i_cmd;
  logic [31:0] i_cmd_param;
  logic        o_cmd_finish;
  logic [15:0] o_cmd_finish_code;
  logic [7:0]  o_gain;
  logic [23:0] o_prf_period;
  logic [15:0] o_sample_cnt;
  logic        o_acq_start;
  logic        o_acq_stop;
  logic        i_acq_done;
  logic        o_busy;

  cmd_exec #(.FINISH_HOLD(FH), .ACQ_TIMEOUT(24'(ACQ_TO))) dut (
    .i_clk_sys         (i_clk_sys),
    .i_rst_n           (i_rst_n),
    .i_cmd_come        (i_cmd_come),
    .i_cmd             (i_cmd),
    .i_cmd_param       (i_cmd_param),
    .o_cmd_finish      (o_cmd_finish),
    .o_cmd_finish_code (o_cmd_finish_code),
    .o_gain            (o_gain),
    .o_prf_period      (o_prf_period),
    .o_sample_cnt      (o_sample_cnt),
    .o_acq_start       (o_acq_start),
    .o_acq_stop        (o_acq_stop),
    .i_acq_done        (i_acq_done),
    .o_busy            (o_busy)
  );

  always #5 i_clk_sys = ~i_clk_sys;

  typedef struct {
    logic [15:0] code;
    logic [7:0]  gain;
    logic [23:0] prf;
    logic [15:0] samples;
    int          nstart;
    int          nstop;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start, n_stop, start_cyc, stop_cyc;

  logic [7:0]  m_gain;
  logic [23:0] m_prf;
  logic [15:0] m_samples;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and note any acquisition pulses
  task automatic tick();
    @(negedge i_clk_sys);
    cyc++;
    if (o_acq_start === 1'b1) begin n_start++; start_cyc = cyc; end
    if (o_acq_stop === 1'b1)  begin n_stop++;  stop_cyc  = cyc; end
  endtask

  task automatic model_reset();
    m_gain = 8'd32; m_prf = 24'd50_000; m_samples = 16'd1024;
  endtask

  function automatic exp_t model(input logic [15:0] c, input logic [31:0] p, input int dly);
    exp_t e;
    e.code = 16'h0000; e.nstart = 0; e.nstop = 0;
    case (c)
      16'h0001: if (p[31:8] != 0) e.code = 16'h0002; else m_gain = p[7:0];
      16'h0002: if (p[31:24] != 0 || p[23:0] < 24'd100) e.code = 16'h0002; else m_prf = p[23:0];
      16'h0003: if (p[15:0] == 0 || p[15:0] > 16'd8192) e.code = 16'h0002; else m_samples = p[15:0];
      16'h0004: begin
        e.nstart = 1;
        if (dly < 0) begin e.code = 16'h0003; e.nstop = 1; end
      end
      16'h0005: e.nstop = 1;
      16'h0006: begin m_gain = 8'd32; m_prf = 24'd50_000; m_samples = 16'd1024; end
      default: e.code = 16'hFFFF;
    endcase
    e.gain = m_gain; e.prf = m_prf; e.samples = m_samples;
    return e;
  endfunction

  // dly >= 0: START answered with done dly cycles after the start pulse
  task automatic run_cmd(input logic [15:0] c, input logic [31:0] p, input int dly);
    exp_t e;
    int lat, w, b, fin_cyc;
    bit seen;
    exp_q.push_back(model(c, p, dly));
    tick();
    n_start = 0; n_stop = 0;
    i_cmd = c; i_cmd_param = p;
    #2 i_cmd_come = 1'b1;
    if (dly >= 0) begin
      seen = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
        tick();
        if (n_start > 0) seen = 1;
      end
      chk("start_seen", 32'(seen), 32'd1);
      repeat (dly) tick();
      chk("fin_before_done", 32'(o_cmd_finish), 32'd0);
      i_acq_done = 1'b1;
      tick();
      chk("fin_after_done", 32'(o_cmd_finish), 32'd1);
      i_acq_done = 1'b0;
    end else begin
      lat = 0;
      while (o_cmd_finish !== 1'b1 && lat < 400) begin tick(); lat++; end
      chk("fin_seen", 32'(o_cmd_finish), 32'd1);
      if (c != 16'h0004) chk("fin_latency", 32'(lat >= 4 && lat <= 5), 32'd1);
      else begin
        chk("timeout_stop_cyc", 32'(stop_cyc - start_cyc), 32'(ACQ_TO));
        chk("timeout_fin_with_stop", 32'(stop_cyc), 32'(cyc));
      end
    end
    fin_cyc = cyc;
    e = exp_q.pop_front();
    chk("code", 32'(o_cmd_finish_code), 32'(e.code));
    chk("gain", 32'(o_gain), 32'(e.gain));
    chk("prf", 32'(o_prf_period), 32'(e.prf));
    chk("samples", 32'(o_sample_cnt), 32'(e.samples));
    chk("busy_at_fin", 32'(o_busy), 32'd1);
    w = 0;
    while (o_cmd_finish === 1'b1 && w < 300) begin tick(); w++; end
    chk("fin_width", 32'(w), 32'(FH));
    i_cmd_come = 1'b0;
    b = w;
    while (o_busy === 1'b1 && b < 300) begin tick(); b++; end
    chk("busy_drop", 32'(b), 32'(2 * FH));
    chk("code_held", 32'(o_cmd_finish_code), 32'(e.code));
    chk("n_start", 32'(n_start), 32'(e.nstart));
    chk("n_stop", 32'(n_stop), 32'(e.nstop));
    if (fin_cyc < 0) chk("cyc_sane", 32'(fin_cyc), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gain"}, 32'(o_gain), 32'd32);
    chk({tag, "_prf"}, 32'(o_prf_period), 32'd50_000);
    chk({tag, "_samples"}, 32'(o_sample_cnt), 32'd1024);
    chk({tag, "_code"}, 32'(o_cmd_finish_code), 32'd0);
    chk({tag, "_finish"}, 32'(o_cmd_finish), 32'd0);
    chk({tag, "_start"}, 32'(o_acq_start), 32'd0);
    chk({tag, "_stop"}, 32'(o_acq_stop), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fin_hi;
    bit seen;
    i_rst_n = 1'b0; i_cmd_come = 1'b0; i_cmd = 16'd0; i_cmd_param = 32'd0;
    i_acq_done = 1'b0;
    n_start = 0; n_stop = 0; start_cyc = 0; stop_cyc = 0;
    model_reset();
    repeat (3) tick();
    chk_reset_vals("rst");
    i_rst_n = 1'b1;
    repeat (3) tick();

    run_cmd(16'h0001, 32'h0000_0050, -1);   // SET_GAIN ok
    run_cmd(16'h0001, 32'h0000_0150, -1);   // SET_GAIN range
    run_cmd(16'h0002, 32'd99, -1);          // SET_PRF below minimum
    run_cmd(16'h0003, 32'd9000, -1);        // SET_SAMPLES above max
    run_cmd(16'h0003, 32'd8192, -1);        // SET_SAMPLES at max
    run_cmd(16'h00AA, 32'h1234_5678, -1);   // unknown
    run_cmd(16'h0005, 32'd0, -1);           // STOP
    run_cmd(16'h0004, 32'd0, 50);           // START answered by done
    run_cmd(16'h0004, 32'd0, -1);           // START timing out

    // Reset in the middle of ACQ_WAIT
    tick();
    n_start = 0;
    i_cmd = 16'h0004; i_cmd_param = 32'd0;
    #2 i_cmd_come = 1'b1;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (n_start > 0) seen = 1;
    end
    chk("mid_start_seen", 32'(seen), 32'd1);
    repeat (10) tick();
    i_rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    i_cmd_come = 1'b0;
    repeat (3) tick();
    i_rst_n = 1'b1;
    fin_hi = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (o_cmd_finish === 1'b1) fin_hi++;
    end
    chk("no_fin_after_abort", 32'(fin_hi), 32'd0);
    chk("idle_after_abort", 32'(o_busy), 32'd0);
    model_reset();

    run_cmd(16'h0002, 32'd200, -1);         // SET_PRF ok
    run_cmd(16'h0006, 32'd0, -1);           // DEFAULTS

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
